// File: rtl/window_gen_3x3_if.sv
// Pixel-in / window-out stream bundle for the 3x3 window generator.
// pix_valid qualifies pix_in and pix_sof. There is no ready signal, so every valid cycle is accepted.
// window_valid and frame_done are single-cycle pulses. window_out is meaningful only while window_valid is high.
interface window_gen_3x3_if;
    logic        pix_valid;
    logic        pix_sof;
    logic [7:0]  pix_in;
    logic [71:0] window_out;
    logic        window_valid;
    logic        frame_done;

    modport master (
        output pix_valid, pix_sof, pix_in,
        input  window_out, window_valid, frame_done
    );

    modport slave (
        input  pix_valid, pix_sof, pix_in,
        output window_out, window_valid, frame_done
    );
endinterface

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator: two row line buffers plus a 3x3 register window.
// Emits one packed window per pixel whose full neighbourhood lies inside the image.
module window_gen_3x3 #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    window_gen_3x3_if.slave  s_if
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] r_col, w_col, w_col_nxt;
    logic [RW-1:0] r_row, w_row, w_row_nxt;
    logic [7:0]    r_lb0 [IMG_W];
    logic [7:0]    r_lb1 [IMG_W];
    logic [7:0]    w_lb0_rd, w_lb1_rd;
    logic [71:0]   r_win, w_win_nxt, r_window_out;
    logic          r_window_valid, r_frame_done;
    logic          w_accept, w_emit, w_last;

    always_comb begin
        w_accept  = s_if.pix_valid;
        // A start-of-frame pixel is always (0,0), whatever the counters hold.
        w_col     = s_if.pix_sof ? '0 : r_col;
        w_row     = s_if.pix_sof ? '0 : r_row;
        w_col_nxt = w_col + 1'b1;
        w_row_nxt = w_row;
        if (w_col == COL_LAST) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
        end
        w_lb0_rd  = r_lb0[w_col];
        w_lb1_rd  = r_lb1[w_col];
        // Shift left one column; the new right column is rows r-2, r-1, r top to bottom.
        w_win_nxt = {r_win[63:48], w_lb0_rd,
                     r_win[39:24], w_lb1_rd,
                     r_win[15:0],  s_if.pix_in};
        w_emit    = w_accept && (w_row >= RW'(2)) && (w_col >= CW'(2));
        w_last    = w_accept && (w_row == ROW_LAST) && (w_col == COL_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col          <= '0;
            r_row          <= '0;
            r_win          <= '0;
            r_window_out   <= '0;
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_col <= w_col_nxt;
                r_row <= w_row_nxt;
                r_win <= w_win_nxt;
            end
            if (w_emit) begin
                r_window_out <= w_win_nxt;
            end
            r_window_valid <= w_emit;
            r_frame_done   <= w_last;
        end
    end

    // Line buffers are left unreset: rows 0 and 1 of every frame rewrite them before any window uses them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb0[w_col] <= w_lb1_rd;
            r_lb1[w_col] <= s_if.pix_in;
        end
    end

    assign s_if.window_out   = r_window_out;
    assign s_if.window_valid = r_window_valid;
    assign s_if.frame_done   = r_frame_done;
endmodule
